audio_to_axi_mc: RTL and testbench

Multi-channel successor to the single-register audio_to_axi slave. It accepts parallel PCM frames of NUM_CHANNELS samples from the audio datapath, serialises each frame into a channel-tagged sample FIFO, and exposes the FIFO to the PS over AXI4-Lite. The AXI4-Lite side also carries control, status, watermark and drop-count registers, and the block drives a level-triggered interrupt. It sits between the I2S/codec receive path and the AXI interconnect.

---
 rtl/audio_to_axi_mc_if.sv | 40 ++++
 rtl/audio_to_axi_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_audio_to_axi_mc.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_to_axi_mc_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and audio_to_axi_mc (slave).
// Handshake rule for every channel: a transfer happens on the rising clock edge where
// both valid and ready are high; a valid, once raised, holds its payload stable until
// that edge, and ready may depend on valid.
interface audio_to_axi_mc_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/audio_to_axi_mc.sv
// Multi-channel PCM capture: parallel frames are serialised into a channel-tagged
// sample FIFO that the PS drains over AXI4-Lite, with control/status/threshold/drop
// registers and a level interrupt.
module audio_to_axi_mc #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int SAMPLE_WIDTH       = 24,
  parameter int NUM_CHANNELS       = 2,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                                 s00_axi_aclk,
  input  logic                                 s00_axi_aresetn,
  input  logic                                 audio_valid,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] audio_data,
  output logic                                 audio_ready,
  output logic                                 irq,
  output logic [0:0]                           fsm_state,
  audio_to_axi_mc_if.slave                     s00_axi
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int ENT_W  = 4 + SAMPLE_WIDTH;
  localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [WORD_W-1:0] REG_CTRL   = WORD_W'(0);
  localparam logic [WORD_W-1:0] REG_STATUS = WORD_W'(1);
  localparam logic [WORD_W-1:0] REG_DATA   = WORD_W'(2);
  localparam logic [WORD_W-1:0] REG_THRESH = WORD_W'(3);
  localparam logic [WORD_W-1:0] REG_DROPS  = WORD_W'(4);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PUSH = 1'b1;

  localparam logic [LVL_W-1:0] DEPTH_L        = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       LAST_CH        = 4'(NUM_CHANNELS - 1);
  localparam logic [4:0]       FRAME_DROP_INC = 5'(NUM_CHANNELS);

  // Serialiser state
  logic [0:0]                           state;
  logic [3:0]                           idx;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] shadow;

  // FIFO storage: entry = {channel, sample}
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  // Registers
  logic        ctrl_enable;
  logic        ctrl_irq_en;
  logic        clear_q;
  logic [7:0]  thresh;
  logic        overrun;
  logic [15:0] drops;

  logic              wr_fire, rd_fire;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic              pop, push_req, push_ok, sample_drop, frame_drop, accept;
  logic              fifo_empty, fifo_full, level_ge;
  logic [4:0]        drop_inc;
  logic [16:0]       drop_sum;
  logic [15:0]       drops_next;
  logic [ENT_W-1:0]  head;
  logic [31:0]       head_word;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign wr_fire = s00_axi.awready & s00_axi.awvalid & s00_axi.wvalid;
  assign rd_fire = s00_axi.arready & s00_axi.arvalid;
  assign wr_word = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_word = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == DEPTH_L);

  // A clear pulse wins over any FIFO traffic on its edge.
  assign pop         = rd_fire & (rd_word == REG_DATA) & ~fifo_empty & ~clear_q;
  assign push_req    = (state == S_PUSH) & ~clear_q;
  assign push_ok     = push_req & (~fifo_full | pop);
  assign sample_drop = push_req & ~push_ok;
  assign frame_drop  = audio_valid & ctrl_enable & (state == S_PUSH);
  assign accept      = audio_valid & ctrl_enable & (state == S_IDLE) & ~clear_q;

  assign audio_ready = ctrl_enable & (state == S_IDLE) & ~clear_q;
  assign fsm_state   = state;

  assign drop_inc   = (frame_drop ? FRAME_DROP_INC : 5'd0) + {4'd0, sample_drop};
  assign drop_sum   = {1'b0, drops} + {12'd0, drop_inc};
  assign drops_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  assign level_ge = (9'(level) >= {1'b0, thresh});

  assign head      = mem[rd_ptr];
  assign head_word = {head[ENT_W-1:SAMPLE_WIDTH],
                      {(28 - SAMPLE_WIDTH){head[SAMPLE_WIDTH-1]}},
                      head[SAMPLE_WIDTH-1:0]};

  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0],
                         s00_axi.araddr[1:0], s00_axi.wdata[C_S_AXI_DATA_WIDTH-1:8],
                         s00_axi.wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

  // Read data selection; an empty DATA read returns 0.
  always_comb begin
    rd_mux = '0;
    case (rd_word)
      REG_CTRL:   rd_mux = {29'd0, ctrl_irq_en, 1'b0, ctrl_enable};
      REG_STATUS: rd_mux = {16'd0, 8'(level), 5'd0, overrun, fifo_full, fifo_empty};
      REG_DATA:   rd_mux = fifo_empty ? 32'd0 : head_word;
      REG_THRESH: rd_mux = {24'd0, thresh};
      REG_DROPS:  rd_mux = {16'd0, drops};
      default:    rd_mux = '0;
    endcase
  end

  // AXI handshakes: one-cycle ready pulses, responses held until accepted.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi.awready <= 1'b0;
      s00_axi.wready  <= 1'b0;
      s00_axi.bvalid  <= 1'b0;
      s00_axi.bresp   <= 2'b00;
      s00_axi.arready <= 1'b0;
      s00_axi.rvalid  <= 1'b0;
      s00_axi.rresp   <= 2'b00;
      s00_axi.rdata   <= '0;
    end else begin
      s00_axi.awready <= s00_axi.awvalid & s00_axi.wvalid & ~s00_axi.bvalid & ~s00_axi.awready;
      s00_axi.wready  <= s00_axi.awvalid & s00_axi.wvalid & ~s00_axi.bvalid & ~s00_axi.awready;
      s00_axi.bresp   <= 2'b00;
      s00_axi.rresp   <= 2'b00;
      if (wr_fire) s00_axi.bvalid <= 1'b1;
      else if (s00_axi.bready) s00_axi.bvalid <= 1'b0;
      s00_axi.arready <= s00_axi.arvalid & ~s00_axi.rvalid & ~s00_axi.arready;
      if (rd_fire) begin
        s00_axi.rvalid <= 1'b1;
        s00_axi.rdata  <= rd_mux;
      end else if (s00_axi.rready) begin
        s00_axi.rvalid <= 1'b0;
      end
    end
  end

  // Control, threshold, overrun and drop-count registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ctrl_enable <= 1'b0;
      ctrl_irq_en <= 1'b0;
      clear_q     <= 1'b0;
      thresh      <= 8'(FIFO_DEPTH / 2);
      overrun     <= 1'b0;
      drops       <= '0;
    end else begin
      clear_q <= 1'b0;
      if (wr_fire && wr_word == REG_CTRL && s00_axi.wstrb[0]) begin
        ctrl_enable <= s00_axi.wdata[0];
        clear_q     <= s00_axi.wdata[1];
        ctrl_irq_en <= s00_axi.wdata[2];
      end
      if (wr_fire && wr_word == REG_THRESH && s00_axi.wstrb[0]) thresh <= s00_axi.wdata[7:0];
      if (clear_q) begin
        overrun <= 1'b0;
        drops   <= '0;
      end else if (frame_drop || sample_drop) begin
        overrun <= 1'b1;
        drops   <= drops_next;
      end else if (wr_fire && wr_word == REG_STATUS && s00_axi.wstrb[0] && s00_axi.wdata[2]) begin
        overrun <= 1'b0;
      end
    end
  end

  // Frame serialiser: latch a frame, then emit one channel per cycle.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state  <= S_IDLE;
      idx    <= '0;
      shadow <= '0;
    end else if (clear_q) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shadow <= audio_data;
            idx    <= '0;
            state  <= S_PUSH;
          end
        end
        S_PUSH: begin
          shadow <= shadow >> SAMPLE_WIDTH;
          if (idx == LAST_CH) state <= S_IDLE;
          else idx <= idx + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and level; push and pop on one edge leave the level unchanged.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear_q) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      level <= level + 1'b1;
      else if (pop && !push_ok) level <= level - 1'b1;
    end
  end

  // FIFO storage write; the lowest shadow slot is always the current channel.
  always_ff @(posedge s00_axi_aclk) begin
    if (push_ok) mem[wr_ptr] <= {idx, shadow[SAMPLE_WIDTH-1:0]};
  end

  // Registered level/overrun interrupt.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) irq <= 1'b0;
    else irq <= ctrl_irq_en & (level_ge | overrun);
  end
endmodule

// File: tb/tb_audio_to_axi_mc.sv
// Bench for audio_to_axi_mc: directed scenarios plus a randomized phase, all checked
// against a transaction-level FIFO/register model.
module tb_audio_to_axi_mc;
  localparam int SW    = 24;
  localparam int NCH   = 2;
  localparam int DEPTH = 16;

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_STATUS = 5'h04;
  localparam logic [4:0] A_DATA   = 5'h08;
  localparam logic [4:0] A_THRESH = 5'h0C;
  localparam logic [4:0] A_DROPS  = 5'h10;
  localparam logic [4:0] A_UNMAP  = 5'h14;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              audio_valid;
  logic [NCH*SW-1:0] audio_data;
  logic              audio_ready;
  logic              irq;
  logic [0:0]        dbg_state_unused;

  audio_to_axi_mc_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi ();

  audio_to_axi_mc #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .SAMPLE_WIDTH(SW),
    .NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .audio_valid(audio_valid), .audio_data(audio_data),
    .audio_ready(audio_ready), .irq(irq), .fsm_state(dbg_state_unused),
    .s00_axi(axi)
  );

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          drops_m;
  bit          overrun_m, en_m, irq_en_m;
  int          thresh_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input int ch, input logic [SW-1:0] s);
    int v;
    v = $signed(s);
    return {ch[3:0], v[27:0]};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    drops_m = 0; overrun_m = 0; en_m = 0; irq_en_m = 0; thresh_m = DEPTH / 2;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    drops_m = 0; overrun_m = 0;
  endfunction

  function automatic void model_drop(input int n);
    drops_m = (drops_m + n > 65535) ? 65535 : drops_m + n;
    overrun_m = 1;
  endfunction

  function automatic void model_push(input int ch, input logic [SW-1:0] s);
    if (exp_q.size() < DEPTH) exp_q.push_back(fmt(ch, s));
    else model_drop(1);
  endfunction

  function automatic logic [31:0] exp_status();
    int lvl;
    lvl = exp_q.size();
    return {16'd0, lvl[7:0], 5'd0, overrun_m, (lvl == DEPTH), (lvl == 0)};
  endfunction

  function automatic logic exp_irq();
    return irq_en_m && ((exp_q.size() >= thresh_m) || overrun_m);
  endfunction

  function automatic logic [NCH*SW-1:0] rand_frame();
    logic [NCH*SW-1:0] d;
    for (int k = 0; k < NCH; k++) d[k*SW +: SW] = SW'($urandom);
    return d;
  endfunction

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data);
    int n;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!axi.bvalid && n < 20);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check_eq("wr_bvalid", {31'd0, axi.bvalid}, 32'd1);
    if (axi.bvalid) begin
      check_eq("bresp", {30'd0, axi.bresp}, 32'd0);
      axi.bready = 1'b1;
      tick();
      axi.bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    int n;
    axi.araddr = addr; axi.arvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!axi.rvalid && n < 20);
    axi.arvalid = 1'b0;
    check_eq("rd_rvalid", {31'd0, axi.rvalid}, 32'd1);
    data = axi.rdata;
    if (axi.rvalid) begin
      check_eq("rresp", {30'd0, axi.rresp}, 32'd0);
      axi.rready = 1'b1;
      tick();
      axi.rready = 1'b0;
    end
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    axi_read(addr, rd);
    check_eq(tag, rd, exp);
  endtask

  task automatic read_data_check(input string tag);
    logic [31:0] rd;
    logic [31:0] exp;
    axi_read(A_DATA, rd);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
    check_eq(tag, rd, exp);
  endtask

  // One frame strobe, then enough idle cycles for serialisation to finish.
  task automatic send_frame(input logic [NCH*SW-1:0] d, input bit model_it);
    audio_data = d; audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0;
    if (model_it && en_m)
      for (int k = 0; k < NCH; k++) model_push(k, d[k*SW +: SW]);
    repeat (NCH + 1) tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0]       rd;
    logic [NCH*SW-1:0] d;
    int                op;

    rst_n = 1'b0; audio_valid = 1'b0; audio_data = '0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_audio_ready", {31'd0, audio_ready}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_awready", {31'd0, axi.awready}, 32'd0);
    check_eq("rst_bvalid", {31'd0, axi.bvalid}, 32'd0);
    check_eq("rst_arready", {31'd0, axi.arready}, 32'd0);
    check_eq("rst_rvalid", {31'd0, axi.rvalid}, 32'd0);
    check_eq("rst_rdata", axi.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset values and readback
    read_check("ctrl_rst", A_CTRL, 32'd0);
    read_check("status_rst", A_STATUS, 32'h1);
    read_check("thresh_rst", A_THRESH, 32'h8);
    read_check("drops_rst", A_DROPS, 32'd0);
    axi_write(A_THRESH, 32'h5); thresh_m = 5;
    read_check("thresh_wr", A_THRESH, 32'h5);
    axi_write(A_UNMAP, 32'hDEADBEEF);
    read_check("unmapped", A_UNMAP, 32'd0);
    axi_write(A_DROPS, 32'hFFFF);
    read_check("drops_ro", A_DROPS, 32'd0);

    // Frame serialisation and sign extension
    axi_write(A_CTRL, 32'h1); en_m = 1;
    check_eq("audio_ready_en", {31'd0, audio_ready}, 32'd1);
    send_frame({24'h800000, 24'h000123}, 1'b1);
    read_check("status_two", A_STATUS, exp_status());
    axi_read(A_DATA, rd); void'(exp_q.pop_front());
    check_eq("data_ch0", rd, 32'h00000123);
    axi_read(A_DATA, rd); void'(exp_q.pop_front());
    check_eq("data_ch1", rd, 32'h1F800000);
    read_check("status_empty", A_STATUS, 32'h1);

    // Frame while busy is dropped whole
    d = rand_frame();
    audio_data = d; audio_valid = 1'b1;
    tick();
    audio_data = rand_frame();
    tick();
    audio_valid = 1'b0;
    for (int k = 0; k < NCH; k++) model_push(k, d[k*SW +: SW]);
    model_drop(NCH);
    repeat (NCH + 1) tick();
    read_check("drops_busy", A_DROPS, drops_m);
    read_check("status_overrun", A_STATUS, exp_status());
    axi_write(A_STATUS, 32'h4); overrun_m = 0;
    read_check("status_ovr_clr", A_STATUS, exp_status());
    read_data_check("data_busy0");
    read_data_check("data_busy1");

    // Fill past full, then read and push on the same edge while full
    axi_write(A_CTRL, 32'h3); model_clear();
    read_check("drops_clr", A_DROPS, 32'd0);
    for (int i = 0; i < 9; i++) send_frame(rand_frame(), 1'b1);
    read_check("status_full", A_STATUS, exp_status());
    read_check("drops_full", A_DROPS, drops_m);
    d = rand_frame();
    fork
      axi_read(A_DATA, rd);
      send_frame(d, 1'b0);
    join
    check_eq("data_full_pop", rd, exp_q.pop_front());
    exp_q.push_back(fmt(0, d[SW-1:0]));
    model_drop(1);
    read_check("status_full_pp", A_STATUS, exp_status());
    read_check("drops_full_pp", A_DROPS, drops_m);
    for (int i = 0; i < 3; i++) read_data_check("data_after_full");

    // Clear with entries queued, then empty read
    axi_write(A_CTRL, 32'h3); model_clear();
    send_frame(rand_frame(), 1'b1);
    send_frame(rand_frame(), 1'b1);
    read_data_check("data_pre_clr");
    read_check("status_three", A_STATUS, exp_status());
    axi_write(A_CTRL, 32'h3); model_clear();
    read_check("status_cleared", A_STATUS, 32'h1);
    read_check("drops_cleared", A_DROPS, 32'd0);
    read_check("data_empty", A_DATA, 32'd0);
    read_check("status_still_empty", A_STATUS, 32'h1);

    // Threshold interrupt timing
    axi_write(A_THRESH, 32'h4); thresh_m = 4;
    axi_write(A_CTRL, 32'h5); irq_en_m = 1;
    check_eq("irq_low0", {31'd0, irq}, 32'd0);
    send_frame(rand_frame(), 1'b1);
    check_eq("irq_low2", {31'd0, irq}, 32'd0);
    d = rand_frame();
    audio_data = d; audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0;
    for (int k = 0; k < NCH; k++) model_push(k, d[k*SW +: SW]);
    tick();
    tick();
    check_eq("irq_at_level4", {31'd0, irq}, 32'd0);
    tick();
    check_eq("irq_rise", {31'd0, irq}, 32'd1);
    read_data_check("data_irq");
    check_eq("irq_fall", {31'd0, irq}, 32'd0);
    axi_write(A_THRESH, 32'h0); thresh_m = 0;
    check_eq("irq_thresh0", {31'd0, irq}, 32'd1);
    axi_write(A_CTRL, 32'h3); model_clear(); irq_en_m = 0;
    check_eq("irq_off", {31'd0, irq}, 32'd0);

    // Disable in the middle of a frame: the frame still completes
    d = rand_frame();
    fork
      axi_write(A_CTRL, 32'h0);
      send_frame(d, 1'b1);
    join
    en_m = 0;
    check_eq("audio_ready_dis", {31'd0, audio_ready}, 32'd0);
    read_check("status_dis_mid", A_STATUS, exp_status());
    send_frame(rand_frame(), 1'b1);
    read_check("status_dis_ign", A_STATUS, exp_status());
    read_check("drops_dis_ign", A_DROPS, drops_m);
    axi_write(A_CTRL, 32'h1); en_m = 1;
    axi_write(A_THRESH, 32'h8); thresh_m = 8;

    // Randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 11);
      if (op <= 4) begin
        send_frame(rand_frame(), 1'b1);
      end else if (op <= 8) begin
        read_data_check("rnd_data");
      end else if (op == 9) begin
        read_check("rnd_status", A_STATUS, exp_status());
        read_check("rnd_drops", A_DROPS, drops_m);
      end else if (op == 10) begin
        en_m = ($urandom_range(0, 3) != 0);
        irq_en_m = $urandom_range(0, 1);
        axi_write(A_CTRL, {29'd0, irq_en_m, 1'b0, en_m});
      end else begin
        axi_write(A_STATUS, 32'h4); overrun_m = 0;
        thresh_m = $urandom_range(0, DEPTH);
        axi_write(A_THRESH, thresh_m);
      end
      check_eq("rnd_irq", {31'd0, irq}, {31'd0, exp_irq()});
    end

    // Reset asserted while serialising
    axi_write(A_THRESH, 32'h0);
    axi_write(A_CTRL, 32'h5);
    audio_data = rand_frame(); audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0;
    check_eq("irq_pre_rst", {31'd0, irq}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ready", {31'd0, audio_ready}, 32'd0);
    check_eq("rst_mid_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();
    read_check("status_post_rst", A_STATUS, 32'h1);
    read_check("ctrl_post_rst", A_CTRL, 32'd0);
    read_check("thresh_post_rst", A_THRESH, 32'h8);
    read_check("drops_post_rst", A_DROPS, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
